// File: rtl/add_sub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package add_sub_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } add_op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } add_flags_t;

endpackage

// File: rtl/carry_skip_adder_32bit.sv
// 32-bit combinational carry-skip adder: eight 4-bit ripple blocks with a
// bypass mux that forwards the block carry-in when every bit propagates.
module carry_skip_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = 32 / BLK_W;

    always_comb begin
        logic [N_BLK:0] blk_c;
        logic           rip_c;
        logic           prop;
        sum      = '0;
        blk_c    = '0;
        blk_c[0] = cin;
        for (int unsigned blk = 0; blk < N_BLK; blk++) begin
            rip_c = blk_c[blk];
            prop  = 1'b1;
            for (int unsigned i = 0; i < BLK_W; i++) begin
                sum[blk*BLK_W+i] = a[blk*BLK_W+i] ^ b[blk*BLK_W+i] ^ rip_c;
                rip_c = (a[blk*BLK_W+i] & b[blk*BLK_W+i]) |
                        ((a[blk*BLK_W+i] ^ b[blk*BLK_W+i]) & rip_c);
                prop  = prop & (a[blk*BLK_W+i] ^ b[blk*BLK_W+i]);
            end
            blk_c[blk+1] = prop ? blk_c[blk] : rip_c;
        end
        cout = blk_c[N_BLK];
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Two-stage valid/ready add/subtract pipeline around carry_skip_adder_32bit.
// Define ADD_SUB_PIPE_SAT_EN to saturate out_sum on signed overflow.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic              in_cin,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_c,
    output logic              out_v,
    output logic              out_z,
    output logic              out_n,
    output logic [TAG_W-1:0]  out_tag
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b_eff;
    logic              s1_cin;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_sum;
    add_flags_t        s2_flags;
    logic [TAG_W-1:0]  s2_tag;

    logic              s2_adv;
    logic              in_fire;
    logic [DATA_W-1:0] b_cond;
    logic              cin_cond;
    logic [DATA_W-1:0] raw_sum;
    logic              raw_cout;
    logic [DATA_W-1:0] res_sum;
    add_flags_t        res_flags;

    assign s2_adv   = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        b_cond   = in_b;
        cin_cond = 1'b0;
        case (add_op_e'(in_op))
            OP_ADD: ;
            OP_SUB: begin
                b_cond   = ~in_b;
                cin_cond = 1'b1;
            end
            OP_ADC: cin_cond = in_cin;
            OP_SBB: begin
                b_cond   = ~in_b;
                cin_cond = in_cin;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b_eff <= '0;
            s1_cin   <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b_eff <= b_cond;
                s1_cin   <= cin_cond;
                s1_tag   <= in_tag;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    carry_skip_adder_32bit u_adder (
        .a    (s1_a),
        .b    (s1_b_eff),
        .cin  (s1_cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    // z/n are registered rather than derived from out_sum so reset can hold them at 0.
    always_comb begin
        res_flags.c = raw_cout;
        res_flags.v = (s1_a[DATA_W-1] == s1_b_eff[DATA_W-1]) &&
                      (raw_sum[DATA_W-1] != s1_a[DATA_W-1]);
`ifdef ADD_SUB_PIPE_SAT_EN
        res_sum = res_flags.v ? (s1_a[DATA_W-1] ? SAT_NEG : SAT_POS) : raw_sum;
`else
        res_sum = raw_sum;
`endif
        res_flags.z = (res_sum == '0);
        res_flags.n = res_sum[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= 1'b1;
                s2_sum   <= res_sum;
                s2_flags <= res_flags;
                s2_tag   <= s1_tag;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_sum   = s2_sum;
    assign out_c     = s2_flags.c;
    assign out_v     = s2_flags.v;
    assign out_z     = s2_flags.z;
    assign out_n     = s2_flags.n;
    assign out_tag   = s2_tag;

endmodule
